// File: rtl/sys_cmd_pkg.sv
// Shared definitions for the UART command-frame master: opcodes, command and FSM encodings,
// and per-command frame/response lengths.
package sys_cmd_pkg;

  localparam logic [7:0] RF_WR_CMD   = 8'hAA;
  localparam logic [7:0] RF_RD_CMD   = 8'hBB;
  localparam logic [7:0] ALU_OP_CMD  = 8'hCC;
  localparam logic [7:0] ALU_NOP_CMD = 8'hDD;

  typedef enum logic [1:0] {
    CMD_RF_WR   = 2'd0,
    CMD_RF_RD   = 2'd1,
    CMD_ALU_OP  = 2'd2,
    CMD_ALU_NOP = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_BUSY = 3'd3,
    RSP_WAIT  = 3'd4,
    DONE      = 3'd5
  } state_e;

  function automatic logic [2:0] frame_len(input cmd_type_e t);
    case (t)
      CMD_RF_WR:  return 3'd3;
      CMD_RF_RD:  return 3'd2;
      CMD_ALU_OP: return 3'd4;
      default:    return 3'd2;
    endcase
  endfunction

  function automatic logic [1:0] rsp_len(input cmd_type_e t);
    case (t)
      CMD_RF_WR: return 2'd0;
      CMD_RF_RD: return 2'd1;
      default:   return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/sys_cmd_frame_mux.sv
// Combinational frame byte selector: picks byte idx of the frame for the registered command.
module sys_cmd_frame_mux
  import sys_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RF_ADDR    = 4
) (
  input  cmd_type_e             cmd_type,
  input  logic [1:0]            idx,
  input  logic [RF_ADDR-1:0]    addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic [3:0]            fun,
  output logic [DATA_WIDTH-1:0] frame_byte
);

  always_comb begin
    frame_byte = '0;
    case (cmd_type)
      CMD_RF_WR: begin
        case (idx)
          2'd0:    frame_byte = DATA_WIDTH'(RF_WR_CMD);
          2'd1:    frame_byte = DATA_WIDTH'(addr);
          2'd2:    frame_byte = wdata;
          default: frame_byte = '0;
        endcase
      end
      CMD_RF_RD: begin
        case (idx)
          2'd0:    frame_byte = DATA_WIDTH'(RF_RD_CMD);
          2'd1:    frame_byte = DATA_WIDTH'(addr);
          default: frame_byte = '0;
        endcase
      end
      CMD_ALU_OP: begin
        case (idx)
          2'd0:    frame_byte = DATA_WIDTH'(ALU_OP_CMD);
          2'd1:    frame_byte = op_a;
          2'd2:    frame_byte = op_b;
          default: frame_byte = DATA_WIDTH'(fun);
        endcase
      end
      default: begin
        case (idx)
          2'd0:    frame_byte = DATA_WIDTH'(ALU_NOP_CMD);
          2'd1:    frame_byte = DATA_WIDTH'(fun);
          default: frame_byte = '0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/sys_cmd_master.sv
// Host-side command master: serialises one command into UART frame bytes, then gathers the
// response bytes (with optional timeout) and reports completion with a one-cycle pulse.
module sys_cmd_master
  import sys_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RF_ADDR    = 4,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_type,
  input  logic [RF_ADDR-1:0]      cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH-1:0]   cmd_op_a,
  input  logic [DATA_WIDTH-1:0]   cmd_op_b,
  input  logic [3:0]              cmd_fun,
  input  logic [TIMEOUT_W-1:0]    timeout_lim,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    TX_Busy,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic                    rsp_valid,
  output logic [2*DATA_WIDTH-1:0] rsp_data,
  output logic                    rsp_timeout
);

  state_e                  state;
  cmd_type_e               type_q;
  logic [RF_ADDR-1:0]      addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   op_a_q;
  logic [DATA_WIDTH-1:0]   op_b_q;
  logic [3:0]              fun_q;
  logic [1:0]              idx;
  logic [1:0]              rcnt;
  logic [TIMEOUT_W-1:0]    tcnt;
  logic                    seen_busy;
  logic [2*DATA_WIDTH-1:0] rx_buf;

  logic [DATA_WIDTH-1:0]   frame_byte;
  logic [2*DATA_WIDTH-1:0] rx_next;
  logic [1:0]              rcnt_next;
  logic [TIMEOUT_W-1:0]    tcnt_next;
  logic                    last_byte;
  logic                    rx_complete;
  logic                    timed_out;

  sys_cmd_frame_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .RF_ADDR   (RF_ADDR)
  ) u_frame_mux (
    .cmd_type  (type_q),
    .idx       (idx),
    .addr      (addr_q),
    .wdata     (wdata_q),
    .op_a      (op_a_q),
    .op_b      (op_b_q),
    .fun       (fun_q),
    .frame_byte(frame_byte)
  );

  // Response byte arriving this cycle, merged so completion and timeout see it immediately.
  always_comb begin
    rx_next   = rx_buf;
    rcnt_next = rcnt;
    if (RX_D_VLD) begin
      if (rcnt == 2'd0) rx_next[DATA_WIDTH-1:0] = RX_P_DATA;
      else              rx_next[2*DATA_WIDTH-1:DATA_WIDTH] = RX_P_DATA;
      rcnt_next = rcnt + 2'd1;
    end
  end

  assign tcnt_next   = tcnt + TIMEOUT_W'(1);
  assign rx_complete = (rcnt_next == rsp_len(type_q));
  assign timed_out   = (timeout_lim != '0) && (tcnt_next == timeout_lim);
  assign last_byte   = ({1'b0, idx} == (frame_len(type_q) - 3'd1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      type_q      <= CMD_RF_WR;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      fun_q       <= '0;
      idx         <= '0;
      rcnt        <= '0;
      tcnt        <= '0;
      seen_busy   <= 1'b0;
      rx_buf      <= '0;
      cmd_ready   <= 1'b1;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      TX_D_VLD  <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            type_q    <= cmd_type_e'(cmd_type);
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            op_a_q    <= cmd_op_a;
            op_b_q    <= cmd_op_b;
            fun_q     <= cmd_fun;
            idx       <= '0;
            rx_buf    <= '0;
            cmd_ready <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          TX_P_DATA <= frame_byte;
          state     <= SEND;
        end
        SEND: begin
          if (!TX_Busy) begin
            TX_D_VLD  <= 1'b1;
            seen_busy <= 1'b0;
            state     <= WAIT_BUSY;
          end
        end
        // A byte counts as sent only after Busy has both risen and fallen again.
        WAIT_BUSY: begin
          if (!seen_busy) begin
            if (TX_Busy) seen_busy <= 1'b1;
          end else if (!TX_Busy) begin
            if (!last_byte) begin
              idx   <= idx + 2'd1;
              state <= LOAD;
            end else if (rsp_len(type_q) == 2'd0) begin
              rsp_valid   <= 1'b1;
              rsp_data    <= rx_buf;
              rsp_timeout <= 1'b0;
              state       <= DONE;
            end else begin
              tcnt  <= '0;
              rcnt  <= '0;
              state <= RSP_WAIT;
            end
          end
        end
        RSP_WAIT: begin
          rx_buf <= rx_next;
          rcnt   <= rcnt_next;
          tcnt   <= tcnt_next;
          if (rx_complete) begin
            rsp_valid   <= 1'b1;
            rsp_data    <= rx_next;
            rsp_timeout <= 1'b0;
            state       <= DONE;
          end else if (timed_out) begin
            rsp_valid   <= 1'b1;
            rsp_data    <= rx_next;
            rsp_timeout <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_cmd_master.sv
// Self-checking bench for sys_cmd_master: a busy-handshaking transmitter model, a byte
// responder and scoreboards for expected frame bytes and responses.
module tb_sys_cmd_master;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TW = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_type;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [DW-1:0] cmd_op_a;
  logic [DW-1:0] cmd_op_b;
  logic [3:0]    cmd_fun;
  logic [TW-1:0] timeout_lim;
  logic [DW-1:0] TX_P_DATA;
  logic          TX_D_VLD;
  logic          TX_Busy;
  logic [DW-1:0] RX_P_DATA;
  logic          RX_D_VLD;
  logic          rsp_valid;
  logic [2*DW-1:0] rsp_data;
  logic          rsp_timeout;

  always #5 CLK = ~CLK;

  sys_cmd_master #(.DATA_WIDTH(DW), .RF_ADDR(AW), .TIMEOUT_W(TW)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_op_a(cmd_op_a),
    .cmd_op_b(cmd_op_b), .cmd_fun(cmd_fun), .timeout_lim(timeout_lim),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_Busy(TX_Busy),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tx_seen = 0;
  int rsp_seen = 0;
  int rsp_cyc = 0;
  int last_fall = 0;
  int busy_cnt = 0;
  int busy_len = 3;
  logic busy_hold = 1'b0;
  logic [7:0]  tx_q[$];
  logic [16:0] rsp_q[$];

  // One clock step: sample at the falling edge, score TX bytes and responses, advance Busy model.
  task automatic tick();
    logic [7:0]  exp_b;
    logic [16:0] exp_r;
    logic        prev;
    @(negedge CLK);
    cyc++;
    if (TX_D_VLD === 1'b1) begin
      tx_seen++;
      checks++;
      if (TX_Busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL tx_strobe_busy: strobe seen with TX_Busy=%b, required 0", TX_Busy);
      end
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL tx_unexpected: got byte %h, required no byte", TX_P_DATA);
      end else begin
        exp_b = tx_q.pop_front();
        if (TX_P_DATA !== exp_b) begin
          errors++;
          $display("[TB] FAIL tx_byte: got %h, required %h", TX_P_DATA, exp_b);
        end
      end
    end
    if (rsp_valid === 1'b1) begin
      rsp_seen++;
      rsp_cyc = cyc;
      checks++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL rsp_unexpected: got to=%b data=%h, required no response",
                 rsp_timeout, rsp_data);
      end else begin
        exp_r = rsp_q.pop_front();
        if ({rsp_timeout, rsp_data} !== exp_r) begin
          errors++;
          $display("[TB] FAIL rsp: got to=%b data=%h, required to=%b data=%h",
                   rsp_timeout, rsp_data, exp_r[16], exp_r[15:0]);
        end
      end
    end
    prev = TX_Busy;
    if (TX_D_VLD === 1'b1) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    TX_Busy = (busy_cnt != 0) || busy_hold;
    if (prev && !TX_Busy) last_fall = cyc;
  endtask

  task automatic issue_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] wd,
                           input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cmd_ready_wait: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      return;
    end
    case (t)
      2'd0: begin tx_q.push_back(8'hAA); tx_q.push_back({4'h0, a}); tx_q.push_back(wd); end
      2'd1: begin tx_q.push_back(8'hBB); tx_q.push_back({4'h0, a}); end
      2'd2: begin
        tx_q.push_back(8'hCC); tx_q.push_back(oa); tx_q.push_back(ob); tx_q.push_back({4'h0, f});
      end
      default: begin tx_q.push_back(8'hDD); tx_q.push_back({4'h0, f}); end
    endcase
    cmd_type  = t;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_op_a  = oa;
    cmd_op_b  = ob;
    cmd_fun   = f;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cmd_ready_drop: cmd_ready=%b after accept, required 0", cmd_ready);
    end
  endtask

  task automatic wait_tx_done();
    int n = 0;
    while ((tx_q.size() != 0 || TX_Busy) && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (tx_q.size() != 0 || TX_Busy) begin
      errors++;
      $display("[TB] FAIL tx_done_wait: %0d bytes outstanding, required 0", tx_q.size());
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
    tick();
  endtask

  task automatic wait_rsp(input int prev);
    int n = 0;
    while (rsp_seen == prev && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (rsp_seen == prev) begin
      errors++;
      $display("[TB] FAIL rsp_wait: %0d responses, required %0d", rsp_seen, prev + 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({cmd_ready, TX_D_VLD, TX_P_DATA, rsp_valid, rsp_data, rsp_timeout} !== {1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("[TB] FAIL %s: rdy=%b vld=%b txd=%h rv=%b rd=%h to=%b, required 1 0 00 0 0000 0",
               tag, cmd_ready, TX_D_VLD, TX_P_DATA, rsp_valid, rsp_data, rsp_timeout);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; cmd_valid = 1'b0; cmd_type = 2'd0; cmd_addr = '0; cmd_wdata = '0;
    cmd_op_a = '0; cmd_op_b = '0; cmd_fun = '0; timeout_lim = '0;
    TX_Busy = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset_values");
    RST = 1'b1;
    repeat (2) tick();
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_rf_wr();
    int prev = rsp_seen;
    rsp_q.push_back({1'b0, 16'h0000});
    issue_cmd(2'd0, 4'd3, 8'h0F, 8'h00, 8'h00, 4'h0);
    wait_rsp(prev);
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL rf_wr_bytes: %0d bytes unsent, required 0", tx_q.size());
    end
  endtask

  task automatic test_rf_rd();
    int prev;
    RX_P_DATA = 8'hEE;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
    prev = rsp_seen;
    rsp_q.push_back({1'b0, 16'h0081});
    issue_cmd(2'd1, 4'd2, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_tx_done();
    repeat (2) tick();
    send_rx(8'h81);
    wait_rsp(prev);
    repeat (5) tick();
    checks++;
    if (rsp_data !== 16'h0081) begin
      errors++;
      $display("[TB] FAIL rsp_hold: got %h, required 0081", rsp_data);
    end
  endtask

  task automatic test_alu_op();
    int prev = rsp_seen;
    rsp_q.push_back({1'b0, 16'h000F});
    issue_cmd(2'd2, 4'd0, 8'h00, 8'h0A, 8'h05, 4'h0);
    wait_tx_done();
    repeat (2) tick();
    send_rx(8'h0F);
    send_rx(8'h00);
    wait_rsp(prev);
  endtask

  task automatic test_timeout();
    int prev = rsp_seen;
    int fall;
    timeout_lim = 16'd100;
    rsp_q.push_back({1'b1, 16'h005A});
    issue_cmd(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'h2);
    wait_tx_done();
    fall = last_fall;
    repeat (2) tick();
    send_rx(8'h5A);
    wait_rsp(prev);
    checks++;
    if (rsp_cyc - fall != 101) begin
      errors++;
      $display("[TB] FAIL timeout_latency: rsp %0d cycles after busy fall, required 101", rsp_cyc - fall);
    end
    timeout_lim = '0;
  endtask

  task automatic test_timeout_boundary();
    int prev = rsp_seen;
    int fall;
    timeout_lim = 16'd20;
    rsp_q.push_back({1'b0, 16'hB2A1});
    issue_cmd(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'h5);
    wait_tx_done();
    fall = last_fall;
    repeat (2) tick();
    send_rx(8'hA1);
    while (cyc < fall + 20) tick();
    RX_P_DATA = 8'hB2;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
    wait_rsp(prev);
    checks++;
    if (rsp_cyc - fall != 21) begin
      errors++;
      $display("[TB] FAIL boundary_latency: rsp %0d cycles after busy fall, required 21", rsp_cyc - fall);
    end
    timeout_lim = '0;
  endtask

  task automatic test_busy_hold();
    int prev = rsp_seen;
    int start = tx_seen;
    int held;
    int n = 0;
    rsp_q.push_back({1'b0, 16'h1234});
    issue_cmd(2'd2, 4'd0, 8'h00, 8'h12, 8'h34, 4'h1);
    while (tx_seen == start && n < 2000) begin
      tick();
      n++;
    end
    busy_hold = 1'b1;
    TX_Busy   = 1'b1;
    held = tx_seen;
    repeat (50) tick();
    checks++;
    if (tx_seen != held) begin
      errors++;
      $display("[TB] FAIL busy_hold_strobes: %0d strobes while held, required 0", tx_seen - held);
    end
    busy_hold = 1'b0;
    wait_tx_done();
    repeat (2) tick();
    send_rx(8'h34);
    send_rx(8'h12);
    wait_rsp(prev);
  endtask

  task automatic test_reset_mid_frame();
    int start = tx_seen;
    int prev;
    int n = 0;
    issue_cmd(2'd2, 4'd0, 8'h00, 8'h55, 8'h66, 4'h7);
    while (tx_seen < start + 2 && n < 2000) begin
      tick();
      n++;
    end
    #2 RST = 1'b0;
    #1 check_reset_outputs("reset_mid_frame");
    tx_q.delete();
    rsp_q.delete();
    busy_cnt  = 0;
    busy_hold = 1'b0;
    TX_Busy   = 1'b0;
    tick();
    RST = 1'b1;
    repeat (2) tick();
    prev = rsp_seen;
    rsp_q.push_back({1'b0, 16'h0000});
    issue_cmd(2'd0, 4'hA, 8'h3C, 8'h00, 8'h00, 4'h0);
    wait_rsp(prev);
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL post_reset_frame: %0d bytes unsent, required 0", tx_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_rf_wr();
    test_rf_rd();
    test_alu_op();
    test_timeout();
    test_timeout_boundary();
    test_busy_hold();
    test_reset_mid_frame();
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
